// File: rtl/fifo_protocol_checker_if.sv
// Observation bundle for a single-clock FIFO.
// master: FIFO side drives everything; slave: passive monitor.
interface fifo_protocol_checker_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] mon_data_in;
  logic             mon_wr_en;
  logic             mon_rd_en;
  logic [WIDTH-1:0] mon_data_out;
  logic             mon_wr_ack;
  logic             mon_overflow;
  logic             mon_underflow;
  logic             mon_full;
  logic             mon_empty;
  logic             mon_almostfull;
  logic             mon_almostempty;

  modport master (
    output mon_data_in, mon_wr_en, mon_rd_en,
    output mon_data_out, mon_wr_ack,
    output mon_overflow, mon_underflow,
    output mon_full, mon_empty,
    output mon_almostfull, mon_almostempty
  );

  modport slave (
    input mon_data_in, mon_wr_en, mon_rd_en,
    input mon_data_out, mon_wr_ack,
    input mon_overflow, mon_underflow,
    input mon_full, mon_empty,
    input mon_almostfull, mon_almostempty
  );
endinterface

// File: rtl/fifo_protocol_checker.sv
// Passive FIFO monitor: shadow model, flag/response/data checks,
// sticky error classes, saturating event and error counters.
// Ports: clk, rst_n (async low), en, clr, mon (slave view),
// err_pulse, err_sticky[6:0], err/wr/rd/ovf/udf counts, occupancy.
module fifo_protocol_checker #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  fifo_protocol_checker_if.slave mon,
  output logic                 err_pulse,
  output logic [6:0]           err_sticky,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] ovf_count,
  output logic [CNT_WIDTH-1:0] udf_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  localparam logic [AW-1:0] P_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [AW-1:0] P_ONE  = AW'(1);
  localparam logic [OW-1:0] C_DEP  = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] C_AF   = OW'(FIFO_DEPTH - 1);
  localparam logic [OW-1:0] C_ONE  = OW'(1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [OW-1:0]         count;

  logic                  exp_wr_ack;
  logic                  exp_ovf;
  logic                  exp_udf;
  logic                  exp_rd_valid;
  logic [FIFO_WIDTH-1:0] exp_data;

  logic exp_full, exp_empty, exp_af, exp_ae;
  logic wr_acc, rd_acc, ovf_c, udf_c;
  logic [6:0] mis;
  logic       any_err;

  assign exp_full  = (count == C_DEP);
  assign exp_af    = (count == C_AF);
  assign exp_empty = (count == '0);
  assign exp_ae    = (count == C_ONE);

  assign wr_acc = mon.mon_wr_en && !exp_full;
  assign rd_acc = mon.mon_rd_en && !exp_empty;
  assign ovf_c  = mon.mon_wr_en && exp_full;
  assign udf_c  = mon.mon_rd_en && exp_empty;

  always_comb begin
    mis    = '0;
    mis[0] = exp_rd_valid &&
             (mon.mon_data_out != exp_data);
    mis[1] = mon.mon_wr_ack != exp_wr_ack;
    mis[2] = mon.mon_overflow != exp_ovf;
    mis[3] = mon.mon_underflow != exp_udf;
    mis[4] = mon.mon_full != exp_full;
    mis[5] = mon.mon_empty != exp_empty;
    mis[6] = (mon.mon_almostfull != exp_af) ||
             (mon.mon_almostempty != exp_ae);
  end

  assign any_err   = en && (|mis);
  assign occupancy = count;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Shadow storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= mon.mon_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      exp_wr_ack   <= 1'b0;
      exp_ovf      <= 1'b0;
      exp_udf      <= 1'b0;
      exp_rd_valid <= 1'b0;
      exp_data     <= '0;
    end else begin
      exp_wr_ack   <= wr_acc;
      exp_ovf      <= ovf_c;
      exp_udf      <= udf_c;
      exp_rd_valid <= rd_acc;
      if (rd_acc)
        exp_data <= mem[rd_ptr];
      if (wr_acc)
        wr_ptr <= (wr_ptr == P_LAST) ? '0 : wr_ptr + P_ONE;
      if (rd_acc)
        rd_ptr <= (rd_ptr == P_LAST) ? '0 : rd_ptr + P_ONE;
      unique case (1'b1)
        wr_acc && !rd_acc: count <= count + C_ONE;
        !wr_acc && rd_acc: count <= count - C_ONE;
        default:           count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse  <= 1'b0;
      err_sticky <= '0;
      err_count  <= '0;
      wr_count   <= '0;
      rd_count   <= '0;
      ovf_count  <= '0;
      udf_count  <= '0;
    end else begin
      err_pulse <= any_err;
      if (clr) begin
        err_sticky <= '0;
        err_count  <= '0;
        wr_count   <= '0;
        rd_count   <= '0;
        ovf_count  <= '0;
        udf_count  <= '0;
      end else begin
        if (en)
          err_sticky <= err_sticky | mis;
        if (any_err)
          err_count <= sat_inc(err_count);
        if (wr_acc)
          wr_count <= sat_inc(wr_count);
        if (rd_acc)
          rd_count <= sat_inc(rd_count);
        if (ovf_c)
          ovf_count <= sat_inc(ovf_count);
        if (udf_c)
          udf_count <= sat_inc(udf_count);
      end
    end
  end

endmodule

// File: tb/tb_fifo_protocol_checker.sv
// Directed bench: behavioural FIFO drives the monitor,
// with injectable data and full-flag corruption.
module tb_fifo_protocol_checker;

  logic clk = 1'b0;
  logic rst_n, en, clr;
  logic wr, rd;
  logic [15:0] din;
  logic force_full, dead_force;

  logic        err_pulse;
  logic [6:0]  err_sticky;
  logic [15:0] err_count, wr_count, rd_count;
  logic [15:0] ovf_count, udf_count;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // reference FIFO, depth 8
  logic [15:0] fmem [8];
  logic [2:0]  fw, fr;
  logic [3:0]  fcnt;
  logic [15:0] fdout;
  logic        fack, fovf, fudf;
  logic        ff, fe, wa, ra;

  assign ff = (fcnt == 4'd8);
  assign fe = (fcnt == 4'd0);
  assign wa = wr && !ff;
  assign ra = rd && !fe;

  always_ff @(posedge clk) begin
    if (wa)
      fmem[fw] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw <= '0; fr <= '0; fcnt <= '0;
      fdout <= '0;
      fack <= 1'b0; fovf <= 1'b0; fudf <= 1'b0;
    end else begin
      fack <= wa;
      fovf <= wr && ff;
      fudf <= rd && fe;
      if (wa) fw <= fw + 3'd1;
      if (ra) begin
        fdout <= fmem[fr];
        fr    <= fr + 3'd1;
      end
      fcnt <= fcnt + 4'(wa) - 4'(ra);
    end
  end

  fifo_protocol_checker_if #(.WIDTH(16)) mon_if ();

  assign mon_if.mon_data_in     = din;
  assign mon_if.mon_wr_en       = wr;
  assign mon_if.mon_rd_en       = rd;
  assign mon_if.mon_data_out    = dead_force ? 16'hDEAD : fdout;
  assign mon_if.mon_wr_ack      = fack;
  assign mon_if.mon_overflow    = fovf;
  assign mon_if.mon_underflow   = fudf;
  assign mon_if.mon_full        = force_full | ff;
  assign mon_if.mon_empty       = fe;
  assign mon_if.mon_almostfull  = (fcnt == 4'd7);
  assign mon_if.mon_almostempty = (fcnt == 4'd1);

  fifo_protocol_checker #(
    .FIFO_WIDTH(16),
    .FIFO_DEPTH(8),
    .CNT_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .mon        (mon_if),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .wr_count   (wr_count),
    .rd_count   (rd_count),
    .ovf_count  (ovf_count),
    .udf_count  (udf_count),
    .occupancy  (occupancy)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic cyc(
    input logic        w,
    input logic        r,
    input logic [15:0] d
  );
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0;
    wr = 1'b0; rd = 1'b0; din = '0;
    force_full = 1'b0; dead_force = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pulse", 32'(err_pulse), 0);
    chk("rst_sticky", 32'(err_sticky), 0);
    chk("rst_errcnt", 32'(err_count), 0);
    chk("rst_occ", 32'(occupancy), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    chk("idle_sticky", 32'(err_sticky), 0);
    chk("idle_errcnt", 32'(err_count), 0);
    chk("idle_occ", 32'(occupancy), 0);

    for (int i = 1; i <= 8; i++) cyc(1, 0, 16'(i));
    chk("fill_wrcnt", 32'(wr_count), 8);
    chk("fill_occ", 32'(occupancy), 8);
    cyc(1, 0, 16'h0009);
    chk("ovf_cnt", 32'(ovf_count), 1);
    chk("ovf_wrcnt", 32'(wr_count), 8);
    cyc(0, 0, 0);
    chk("ovf_sticky", 32'(err_sticky), 0);
    chk("ovf_errcnt", 32'(err_count), 0);

    for (int i = 0; i < 9; i++) cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("drain_rdcnt", 32'(rd_count), 8);
    chk("drain_udf", 32'(udf_count), 1);
    chk("drain_occ", 32'(occupancy), 0);
    chk("drain_sticky", 32'(err_sticky), 0);

    for (int i = 0; i < 4; i++) cyc(1, 0, 16'h0010 + 16'(i));
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    dead_force = 1'b1;
    cyc(0, 0, 0);
    chk("data_pulse", 32'(err_pulse), 1);
    chk("data_sticky", 32'(err_sticky), 32'h01);
    chk("data_errcnt", 32'(err_count), 1);
    dead_force = 1'b0;
    cyc(0, 0, 0);
    chk("data_pulse_off", 32'(err_pulse), 0);
    chk("data_errcnt_hold", 32'(err_count), 1);
    chk("data_occ", 32'(occupancy), 1);
    clr = 1'b1;
    cyc(0, 0, 0);
    clr = 1'b0;
    chk("clr1_errcnt", 32'(err_count), 0);

    cyc(1, 0, 16'h0020);
    cyc(1, 0, 16'h0021);
    force_full = 1'b1;
    cyc(0, 0, 0);
    chk("full_pulse1", 32'(err_pulse), 1);
    cyc(0, 0, 0);
    force_full = 1'b0;
    chk("full_errcnt", 32'(err_count), 2);
    chk("full_sticky", 32'(err_sticky), 32'h10);
    cyc(0, 0, 0);
    chk("full_pulse_off", 32'(err_pulse), 0);
    clr = 1'b1;
    cyc(0, 0, 0);
    clr = 1'b0;
    chk("clr2_errcnt", 32'(err_count), 0);
    chk("clr2_sticky", 32'(err_sticky), 0);
    chk("clr2_wrcnt", 32'(wr_count), 0);
    chk("clr2_udf", 32'(udf_count), 0);
    chk("clr2_occ", 32'(occupancy), 3);

    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    chk("sim_pre_occ", 32'(occupancy), 0);
    cyc(1, 1, 16'h0055);
    chk("sim_e_occ", 32'(occupancy), 1);
    chk("sim_e_udf", 32'(udf_count), 1);
    chk("sim_e_wrcnt", 32'(wr_count), 1);
    chk("sim_e_rdcnt", 32'(rd_count), 3);
    for (int i = 0; i < 7; i++) cyc(1, 0, 16'h0060 + 16'(i));
    chk("sim_pre_full", 32'(occupancy), 8);
    cyc(1, 1, 16'h0077);
    chk("sim_f_occ", 32'(occupancy), 7);
    chk("sim_f_ovf", 32'(ovf_count), 1);
    chk("sim_f_wrcnt", 32'(wr_count), 8);
    chk("sim_f_rdcnt", 32'(rd_count), 4);
    cyc(0, 0, 0);
    chk("sim_errcnt", 32'(err_count), 0);
    chk("sim_sticky", 32'(err_sticky), 0);

    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("mid_occ", 32'(occupancy), 5);
    #2;
    rst_n = 1'b0;
    dead_force = 1'b1;
    #1;
    chk("arst_occ", 32'(occupancy), 0);
    chk("arst_wrcnt", 32'(wr_count), 0);
    chk("arst_rdcnt", 32'(rd_count), 0);
    chk("arst_ovf", 32'(ovf_count), 0);
    chk("arst_udf", 32'(udf_count), 0);
    chk("arst_pulse", 32'(err_pulse), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 0);
    dead_force = 1'b0;
    cyc(1, 0, 16'h00A1);
    cyc(1, 0, 16'h00A2);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("post_sticky", 32'(err_sticky), 0);
    chk("post_errcnt", 32'(err_count), 0);
    chk("post_wrcnt", 32'(wr_count), 2);
    chk("post_rdcnt", 32'(rd_count), 2);
    chk("post_occ", 32'(occupancy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
